vcii_test_sequencer: RTL

VCII_TEST_SEQUENCER -- requirements
Module: vcii_test_sequencer

---
 rtl/vcii_test_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/vcii_test_sequencer.sv
// vcii_test_sequencer: steps a VCII test fixture through up to four analog
// switch configurations. For each selected configuration it opens all
// switches for BBM_CYC cycles, closes the selected switch, waits for the
// settle time, strobes the external sampler and captures the comparator.
// Optional build macro: VCII_SEQ_SYNC_EN -- when defined, cmp_in passes
// through a two-flop synchronizer before capture; otherwise it is captured
// directly in the SAMPLE cycle.
module vcii_test_sequencer #(
  parameter int BBM_CYC = 2,
  parameter int NUM_CFG = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               start,
  input  logic               abort,
  input  logic [NUM_CFG-1:0] cfg_mask,
  input  logic [7:0]         settle,
  input  logic               cmp_in,
  output logic [NUM_CFG-1:0] sw_en,
  output logic               sample,
  output logic               busy,
  output logic               done,
  output logic [NUM_CFG-1:0] result
);

  localparam int IDX_W = $clog2(NUM_CFG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BBM,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_CFG-1:0] mask_q, mask_d;
  logic [NUM_CFG-1:0] result_q, result_d;
  logic [7:0]         settle_q, settle_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               cmp_cap;
  logic [IDX_W-1:0]   first_idx;
  logic [IDX_W-1:0]   next_idx;
  logic               next_valid;

`ifdef VCII_SEQ_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], cmp_in};
    end
  end

  assign cmp_cap = sync_q[1];
`else
  assign cmp_cap = cmp_in;
`endif

  // Priority scans: lowest set bit of the incoming mask, and the next set bit
  // of the latched mask strictly above the current index.
  always_comb begin
    first_idx  = '0;
    next_idx   = '0;
    next_valid = 1'b0;
    for (int i = NUM_CFG - 1; i >= 0; i--) begin
      if (cfg_mask[i]) begin
        first_idx = IDX_W'(i);
      end
      if (mask_q[i] && (i > int'(idx_q))) begin
        next_idx   = IDX_W'(i);
        next_valid = 1'b1;
      end
    end
  end

  // Next-state logic; abort (or loss of enable mid-run) overrides everything.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    result_d = result_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    if (abort || (!ena && (state_q != S_IDLE))) begin
      // Partially measured configurations keep their captured bits.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && ena) begin
            result_d = '0;
            if (cfg_mask != '0) begin
              mask_d   = cfg_mask;
              settle_d = (settle == 8'd0) ? 8'd1 : settle;
              idx_d    = first_idx;
              cnt_d    = 8'(BBM_CYC - 1);
              state_d  = S_BBM;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_BBM: begin
          if (cnt_q == 8'd0) begin
            cnt_d   = settle_q - 8'd1;
            state_d = S_SETTLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        S_SETTLE: begin
          if (cnt_q == 8'd0) begin
            state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        S_SAMPLE: begin
          result_d[idx_q] = cmp_cap;
          if (next_valid) begin
            idx_d   = next_idx;
            cnt_d   = 8'(BBM_CYC - 1);
            state_d = S_BBM;
          end else begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      mask_q   <= '0;
      result_q <= '0;
      settle_q <= 8'd1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      result_q <= result_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decode directly from the state so a switch is only ever closed
  // in SETTLE/SAMPLE, and BBM always separates two closed configurations.
  always_comb begin
    sw_en = '0;
    if ((state_q == S_SETTLE) || (state_q == S_SAMPLE)) begin
      sw_en[idx_q] = 1'b1;
    end
  end

  assign sample = (state_q == S_SAMPLE);
  assign busy   = (state_q == S_BBM) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
